// File: rtl/adder_sched.sv
// adder_sched: round-robin scheduler sharing one combinational adder among
// N_REQ requesters. A granted request has its operands registered onto the
// adder. The adder result is captured one cycle later and returned with the
// requester index over a valid/ready handshake.
//
// Build option: define ADDER_SCHED_FIXED_PRIO_EN for fixed priority, where the
// lowest index wins and no round-robin pointer exists. Without it, the default
// build uses round-robin arbitration.
module adder_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   Clk_in,
    input  logic                   Reset_n_in,
    input  logic [N_REQ-1:0]       Req_in,
    input  logic [N_REQ*WIDTH-1:0] A_in,
    input  logic [N_REQ*WIDTH-1:0] B_in,
    input  logic [N_REQ-1:0]       Sel_in,
    output logic [N_REQ-1:0]       Gnt_out,
    output logic [WIDTH-1:0]       Adder_A_out,
    output logic [WIDTH-1:0]       Adder_B_out,
    output logic                   Adder_Sel_out,
    input  logic [WIDTH:0]         Adder_Rez_in,
    output logic [WIDTH:0]         Rez_out,
    output logic [ID_W-1:0]        Rez_id_out,
    output logic                   Rez_valid_out,
    input  logic                   Rez_ready_in,
    output logic                   Busy_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    // N_REQ at the width of the wrap-around sum, so the modulo compare is exact
    localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [N_REQ-1:0] gnt_reg;
    logic [WIDTH-1:0] adder_a_reg;
    logic [WIDTH-1:0] adder_b_reg;
    logic             adder_sel_reg;
    logic [ID_W-1:0]  op_id_reg;
    logic [WIDTH:0]   rez_reg;
    logic [ID_W-1:0]  rez_id_reg;
    logic             rez_valid_reg;

    logic             grant_en;
    logic             capture_en;
    logic             win_found;
    logic [ID_W-1:0]  win_idx;
    logic [ID_W:0]    cand_sum;
    logic [N_REQ-1:0] win_onehot;
    logic [ID_W-1:0]  search_base;

    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];

    // Unpack the requester operand buses and build the one-hot winner vector
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign a_arr[gi]      = A_in[gi*WIDTH +: WIDTH];
            assign b_arr[gi]      = B_in[gi*WIDTH +: WIDTH];
            assign win_onehot[gi] = win_found && (win_idx == ID_W'(gi));
        end
    endgenerate

`ifdef ADDER_SCHED_FIXED_PRIO_EN
    // Searching from N_REQ-1 + 1 always starts at index 0, so the lowest index wins
    localparam logic [ID_W-1:0] FIXED_BASE = ID_W'(N_REQ - 1);
    assign search_base = FIXED_BASE;
`else
    logic [ID_W-1:0] last_reg;

    // Round-robin pointer: remembers the most recent winner
    always_ff @(posedge Clk_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            last_reg <= ID_W'(N_REQ - 1);
        end else if (grant_en) begin
            last_reg <= win_idx;
        end
    end

    assign search_base = last_reg;
`endif

    // Search for the first active request starting one past the search base, wrapping modulo N_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_sum = {1'b0, search_base} + (ID_W+1)'(k);
            if (cand_sum >= N_REQ_W) begin
                cand_sum = cand_sum - N_REQ_W;
            end
            if (!win_found && Req_in[cand_sum[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[ID_W-1:0];
            end
        end
    end

    // Next-state decision; a grant is only possible from IDLE or when the held result is consumed
    always_comb begin
        state_next = state_reg;
        grant_en   = 1'b0;
        capture_en = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    grant_en   = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture_en = 1'b1;
                state_next = ST_RESULT;
            end
            ST_RESULT: begin
                if (rez_valid_reg && Rez_ready_in) begin
                    if (win_found) begin
                        grant_en   = 1'b1;
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, grant pulse, adder operand registers and result capture
    always_ff @(posedge Clk_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            state_reg     <= ST_IDLE;
            gnt_reg       <= '0;
            adder_a_reg   <= '0;
            adder_b_reg   <= '0;
            adder_sel_reg <= 1'b0;
            op_id_reg     <= '0;
            rez_reg       <= '0;
            rez_id_reg    <= '0;
            rez_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= grant_en ? win_onehot : '0;
            if (grant_en) begin
                adder_a_reg   <= a_arr[win_idx];
                adder_b_reg   <= b_arr[win_idx];
                adder_sel_reg <= Sel_in[win_idx];
                op_id_reg     <= win_idx;
            end
            if (capture_en) begin
                // The id follows the result so Rez_id_out always names the owner of Rez_out
                rez_reg       <= Adder_Rez_in;
                rez_id_reg    <= op_id_reg;
                rez_valid_reg <= 1'b1;
            end else if (rez_valid_reg && Rez_ready_in) begin
                rez_valid_reg <= 1'b0;
            end
        end
    end

    assign Gnt_out       = gnt_reg;
    assign Adder_A_out   = adder_a_reg;
    assign Adder_B_out   = adder_b_reg;
    assign Adder_Sel_out = adder_sel_reg;
    assign Rez_out       = rez_reg;
    assign Rez_id_out    = rez_id_reg;
    assign Rez_valid_out = rez_valid_reg;
    assign Busy_out      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adder_sched.sv
// Testbench for adder_sched: directed reset and handshake sequences, a vector
// table, then randomized traffic checked against a transaction-level model.
module tb_adder_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

`ifdef ADDER_SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req;
    logic [N*W-1:0] a_bus;
    logic [N*W-1:0] b_bus;
    logic [N-1:0] sel;
    logic [N-1:0] gnt;
    logic [W-1:0] ad_a;
    logic [W-1:0] ad_b;
    logic         ad_sel;
    logic [W:0]   ad_rez;
    logic [W:0]   rez;
    logic [IW-1:0] rez_id;
    logic         valid;
    logic         ready;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Shared adder: Sel=0 adds, Sel=1 subtracts (9-bit wrap)
    assign ad_rez = ad_sel ? ({1'b0, ad_a} - {1'b0, ad_b}) : ({1'b0, ad_a} + {1'b0, ad_b});

    adder_sched #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .Clk_in        (clk),
        .Reset_n_in    (rst_n),
        .Req_in        (req),
        .A_in          (a_bus),
        .B_in          (b_bus),
        .Sel_in        (sel),
        .Gnt_out       (gnt),
        .Adder_A_out   (ad_a),
        .Adder_B_out   (ad_b),
        .Adder_Sel_out (ad_sel),
        .Adder_Rez_in  (ad_rez),
        .Rez_out       (rez),
        .Rez_id_out    (rez_id),
        .Rez_valid_out (valid),
        .Rez_ready_in  (ready),
        .Busy_out      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_all(input logic [N-1:0] mask, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic s);
        req = mask;
        for (int i = 0; i < N; i++) begin
            a_bus[i*W +: W] = a;
            b_bus[i*W +: W] = b;
        end
        sel = s ? {N{1'b1}} : '0;
    endtask

    function automatic logic [W:0] add_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int r;
        r = s ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        return (W+1)'(r & ((1 << (W+1)) - 1));
    endfunction

    // Round-robin choice: first active index after base, wrapping
    function automatic int rr_pick(input int base, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (base + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Directed vector table
    typedef struct {
        logic [N-1:0]  req;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          sel;
        logic [N-1:0]  gnt;
        logic [IW-1:0] id;
        logic [W:0]    rez;
    } vec_t;

    vec_t vt [6];

    // Transaction-level model state for the random phase
    int           m_last;
    bit           m_inflight;
    bit           m_valid;
    logic [N-1:0] m_gnt;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_sel;
    int           m_op_id;
    logic [W:0]   m_rez;
    int           m_id;

    task automatic model_step();
        bit consume;
        bit capture;
        bit slot;
        int w;
        consume = m_valid && ready;
        capture = m_inflight;
        slot    = !m_inflight && (!m_valid || consume);
        m_gnt   = '0;
        if (capture) begin
            m_rez      = add_fn(m_a, m_b, m_sel);
            m_id       = m_op_id;
            m_valid    = 1'b1;
            m_inflight = 1'b0;
        end else if (consume) begin
            m_valid = 1'b0;
        end
        if (slot && req != '0) begin
            w          = rr_pick(FIXED ? N - 1 : m_last, req);
            m_gnt      = N'(1) << w;
            m_a        = a_bus[w*W +: W];
            m_b        = b_bus[w*W +: W];
            m_sel      = sel[w];
            m_op_id    = w;
            m_inflight = 1'b1;
            if (!FIXED) m_last = w;
        end
    endtask

    logic [N-1:0] rr_gnt_seq [5];
    logic [N-1:0] exp_g;
    bit pend [N];
    bit rel  [N];

    initial begin
        vt[0] = '{req: 4'b0100, a: 8'd200, b: 8'd100, sel: 1'b0, gnt: 4'b0100, id: 2'd2, rez: 9'd300};
        vt[1] = '{req: 4'b1111, a: 8'd10,  b: 8'd3,   sel: 1'b1, gnt: FIXED ? 4'b0001 : 4'b1000,
                  id: FIXED ? 2'd0 : 2'd3, rez: 9'd7};
        vt[2] = '{req: 4'b0011, a: 8'd255, b: 8'd255, sel: 1'b0, gnt: 4'b0001, id: 2'd0, rez: 9'd510};
        vt[3] = '{req: 4'b1010, a: 8'd0,   b: 8'd1,   sel: 1'b1, gnt: 4'b0010, id: 2'd1, rez: 9'h1FF};
        vt[4] = '{req: 4'b1100, a: 8'd128, b: 8'd128, sel: 1'b0, gnt: 4'b0100, id: 2'd2, rez: 9'd256};
        vt[5] = '{req: 4'b1001, a: 8'd50,  b: 8'd60,  sel: 1'b1, gnt: FIXED ? 4'b0001 : 4'b1000,
                  id: FIXED ? 2'd0 : 2'd3, rez: 9'h1F6};
        rr_gnt_seq[0] = 4'b0001;
        rr_gnt_seq[1] = FIXED ? 4'b0001 : 4'b0010;
        rr_gnt_seq[2] = FIXED ? 4'b0001 : 4'b0100;
        rr_gnt_seq[3] = FIXED ? 4'b0001 : 4'b1000;
        rr_gnt_seq[4] = 4'b0001;

        ready = 1'b1;
        set_all(4'b1111, 8'd11, 8'd22, 1'b0);

        // Reset held with all requests high: everything stays zero
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_valid", valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rez", rez, 0);
            chk("rst_adA", ad_a, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_first_gnt", gnt, 4'b0001);
        chk("rst_first_adA", ad_a, 8'd11);

        // Reset pulse during EXEC: result must never appear, pointer returns to N-1
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        chk("midrst_valid", valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_regrant0", gnt, 4'b0001);
        set_all('0, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        chk("midrst_res_valid", valid, 1);
        chk("midrst_res_rez", rez, 9'd33);
        chk("midrst_res_id", rez_id, 0);
        @(negedge clk);
        chk("midrst_idle", busy, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table, each from IDLE with ready high
        for (int v = 0; v < 6; v++) begin
            set_all(vt[v].req, vt[v].a, vt[v].b, vt[v].sel);
            ready = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", v), gnt, vt[v].gnt);
            chk($sformatf("vec%0d_adA", v), ad_a, vt[v].a);
            chk($sformatf("vec%0d_adB", v), ad_b, vt[v].b);
            chk($sformatf("vec%0d_adSel", v), ad_sel, vt[v].sel);
            set_all('0, 8'd0, 8'd0, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", v), valid, 1);
            chk($sformatf("vec%0d_rez", v), rez, vt[v].rez);
            chk($sformatf("vec%0d_id", v), rez_id, vt[v].id);
            chk($sformatf("vec%0d_gnt_off", v), gnt, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_done", v), valid, 0);
            chk($sformatf("vec%0d_idle", v), busy, 0);
        end

        // All four requesting with ready high: a grant every other cycle in rotation
        set_all(4'b1111, 8'd1, 8'd2, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_g = (c % 2 == 0) ? rr_gnt_seq[c/2] : '0;
            chk($sformatf("rr_gnt_c%0d", c), gnt, exp_g);
            chk($sformatf("rr_valid_c%0d", c), valid, (c % 2));
            if (c % 2 == 1) chk($sformatf("rr_id_c%0d", c), 32'(rr_gnt_seq[c/2]), 32'(N'(1) << rez_id));
        end
        set_all('0, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        chk("rr_idle", busy, 0);

        // Backpressure: result held, no grants, then grant on the consuming edge
        set_all(4'b0100, 8'd7, 8'd9, 1'b0);
        ready = 1'b0;
        @(negedge clk);
        chk("bp_gnt2", gnt, 4'b0100);
        set_all(4'b0010, 8'd20, 8'd5, 1'b1);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            chk("bp_hold_gnt", gnt, 0);
            chk("bp_hold_valid", valid, 1);
            chk("bp_hold_rez", rez, 9'd16);
            chk("bp_hold_id", rez_id, 2);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("bp_release_gnt", gnt, 4'b0010);
        chk("bp_release_valid", valid, 0);
        set_all('0, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        chk("bp_next_rez", rez, 9'd15);
        chk("bp_next_id", rez_id, 1);
        @(negedge clk);
        chk("bp_idle", busy, 0);

        // Dropped request: requester 1 withdraws while 3 is served
        set_all(4'b1000, 8'd3, 8'd4, 1'b0);
        ready = 1'b0;
        @(negedge clk);
        chk("drop_gnt3", gnt, 4'b1000);
        req = 4'b1010;
        @(negedge clk);
        chk("drop_valid", valid, 1);
        chk("drop_id", rez_id, 3);
        req = 4'b0000;
        ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("drop_no_gnt", gnt, 0);
        end
        chk("drop_idle", busy, 0);

        // Randomized traffic against the model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = N - 1; m_inflight = 0; m_valid = 0; m_gnt = '0;
        m_a = '0; m_b = '0; m_sel = 1'b0; m_op_id = 0; m_rez = '0; m_id = 0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; rel[i] = 0; end
        set_all('0, 8'd0, 8'd0, 1'b0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_gnt", gnt, m_gnt);
            chk("rnd_valid", valid, m_valid);
            chk("rnd_busy", busy, (m_valid || m_inflight));
            chk("rnd_rez", rez, m_rez);
            chk("rnd_id", rez_id, m_id);
            chk("rnd_adA", ad_a, m_a);
            chk("rnd_adB", ad_b, m_b);
            chk("rnd_adSel", ad_sel, m_sel);
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    rel[i] = 1;
                end else begin
                    if (rel[i]) begin rel[i] = 0; pend[i] = 0; end
                    if (!pend[i]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            pend[i] = 1;
                            a_bus[i*W +: W] = W'($urandom);
                            b_bus[i*W +: W] = W'($urandom);
                            sel[i] = 1'($urandom);
                        end
                    end else if ($urandom_range(0, 39) == 0) begin
                        pend[i] = 0;
                    end
                end
                req[i] = pend[i];
            end
            ready = ($urandom_range(0, 9) < 7);
            model_step();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_sched.md
# adder_sched

Round-robin scheduler that shares the single combinational `adder` (8-bit operands, `Sel_in` mode, 9-bit `Rez_out`) among `N_REQ` requesters. It arbitrates requests and registers the winner's operands onto the adder inputs. It then captures the adder result and returns it, tagged with the requester index, over a valid/ready handshake. It sits between the requester blocks and the shared adder instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: operand width; the adder result is `WIDTH+1` bits.
- `ID_W`, default 2: width of the requester index, equal to clog2(`N_REQ`).

- `Clk_in`  in  1  single clock; all state changes on its rising edge.
- `Reset_n_in`  in  1  asynchronous, active-low reset.
- `Req_in`  in  N_REQ  per-requester request level.
- `A_in`  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `B_in`  in  N_REQ*WIDTH  operand B, packed the same way.
- `Sel_in`  in  N_REQ  per-requester mode bit, passed to the adder unchanged.
- `Gnt_out`  out  N_REQ  one-hot acceptance pulse.
- `Adder_A_out`  out  WIDTH  drives the adder's `A_in`.
- `Adder_B_out`  out  WIDTH  drives the adder's `B_in`.
- `Adder_Sel_out`  out  1  drives the adder's `Sel_in`.
- `Adder_Rez_in`  in  WIDTH+1  the adder's `Rez_out`.
- `Rez_out`  out  WIDTH+1  captured result.
- `Rez_id_out`  out  ID_W  index of the requester that owns `Rez_out`.
- `Rez_valid_out`  out  1  result valid.
- `Rez_ready_in`  in  1  consumer accepts the result.
- `Busy_out`  out  1  high whenever state is not IDLE.

## Operation
- States:
  - IDLE: no operation in flight.
  - EXEC: operands are on the adder, result settling.
  - RESULT: result held, waiting for the consumer.
- IDLE: if any `Req_in` bit is high at the clock edge, the scheduler:
  - picks a winner by arbitration;
  - registers the winner's A, B and Sel into `Adder_*_out`;
  - registers the one-hot winner into `Gnt_out` and the winner index into the id register;
  - moves to EXEC.
- EXEC: unconditionally captures `Adder_Rez_in` into `Rez_out`, sets `Rez_valid_out`, and moves to RESULT. `Adder_*_out` hold their values through EXEC.
- RESULT: `Rez_out`, `Rez_id_out` and `Rez_valid_out` stay stable until `Rez_valid_out & Rez_ready_in` is seen at an edge. At that edge:
  - `Rez_valid_out` clears;
  - if any `Req_in` bit is high, the next winner is granted in the same edge (as in IDLE) and the state goes to EXEC;
  - otherwise the state goes to IDLE.
- Round-robin: a pointer `last` holds the most recent winner. The search starts at index `last+1` and wraps modulo `N_REQ`. The first requester found with a high request wins, and `last` updates to that winner.
- The scheduler does no arithmetic. The result width is `WIDTH+1`, taken from the adder without modification.
- Requester rules:
  - keep `Req_in[i]`, the operands and Sel stable until it samples `Gnt_out[i]` high;
  - it may change or drop them at that edge;
  - a request dropped before the grant is simply not served.
- `Adder_*_out` keep their last values in IDLE and RESULT; they are not cleared.

## Timing
- Reset values:
  - `Gnt_out`=0, `Adder_A_out`=0, `Adder_B_out`=0, `Adder_Sel_out`=0;
  - `Rez_out`=0, `Rez_id_out`=0, `Rez_valid_out`=0, `Busy_out`=0;
  - state=IDLE, `last`=`N_REQ-1`, so requester 0 has first priority.
- Edge k samples a request → `Gnt_out` is high for exactly the one cycle after edge k.
- Edge k+1 captures the adder output → `Rez_valid_out` is high from the cycle after edge k+1. Latency from the sampled request to a valid result is 2 cycles.
- With `Rez_ready_in` tied high: one operation every 2 cycles, so `Gnt_out` pulses every other cycle.
- Backpressure: `Rez_ready_in` low holds RESULT indefinitely; no new grants are issued while held.
- Reset asserted mid-operation: all registers go to their reset values immediately. Any in-flight operation and any unconsumed result are discarded. Operation resumes on the first edge after release.

## Configuration
- `ADDER_SCHED_FIXED_PRIO_EN`:
  - defined: fixed priority, where the lowest-index requester with a high request always wins; the `last` pointer is not implemented.
  - undefined (default): round-robin as described above.
- All timing and handshake behaviour is identical in both builds.

## Test plan
- Reset: hold `Reset_n_in`=0 with all requests high → every output is 0 and no `Gnt_out` pulse occurs; after release, requester 0 is granted first.
- Single request: requester 2 with A=200, B=100, Sel=0 and `Rez_ready_in`=1 → `Gnt_out`=4'b0100 for one cycle; 2 cycles after the sampled request, `Rez_out` equals the adder's output (9'd300 for the add mode) with `Rez_id_out`=2.
- Round-robin: all 4 requesters held high with ready high → grants in order 0,1,2,3,0, one every 2 cycles. With `ADDER_SCHED_FIXED_PRIO_EN` defined → requester 0 is granted every time.
- Backpressure: `Rez_ready_in`=0 for 10 cycles while a result is valid → `Rez_out`/`Rez_id_out` stay stable and no grants occur; on ready=1, the next grant is issued on the same edge.
- Mid-operation reset: pulse `Reset_n_in` low during EXEC → `Rez_valid_out` never rises for that operation and `last` returns to 3.
- Dropped request: requester 1 deasserts while requester 3 is being served → requester 1 is never granted.
